// File: rtl/fifo_arb_ctrl.sv
// Read-side arbiter/controller between two upstream virtual-channel FIFOs and two
// destination FIFOs. Strict VC0-over-VC1 priority, destination chosen by the data MSB.
module fifo_arb_ctrl #(
   parameter int unsigned data_width = 6
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  init,
   input  logic [3:0]            umbral_D0_in,
   input  logic [3:0]            umbral_D1_in,
   input  logic                  vc0_empty,
   input  logic                  vc1_empty,
   input  logic [data_width-1:0] vc0_data,
   input  logic [data_width-1:0] vc1_data,
   input  logic                  d0_almost_full,
   input  logic                  d1_almost_full,
   input  logic [3:0]            error_in,
   output logic [4:0]            state,
   output logic                  fifo_init,
   output logic [3:0]            umbral_D0,
   output logic [3:0]            umbral_D1,
   output logic                  vc0_rd,
   output logic                  vc1_rd,
   output logic                  d0_wr,
   output logic                  d1_wr,
   output logic [data_width-1:0] data_out,
   output logic                  idle_out
);

   localparam int unsigned STATE_W = 5;

   typedef enum logic [STATE_W-1:0] {
      ST_RESET  = 5'b00001,
      ST_INIT   = 5'b00010,
      ST_IDLE   = 5'b00100,
      ST_ACTIVE = 5'b01000,
      ST_ERROR  = 5'b10000
   } state_t;

   state_t state_q;
   state_t state_d;
   logic   rd0_d;
   logic   rd1_d;
   logic   any_err;
   logic   in_flight;
   logic   rd_ok;

   assign any_err   = |error_in;
   assign in_flight = vc0_rd | vc1_rd;

   // Next-state and read-grant decode
   always_comb begin
      state_d = state_q;
      rd0_d   = 1'b0;
      rd1_d   = 1'b0;
      rd_ok   = 1'b0;
      case (state_q)
         ST_RESET: state_d = ST_INIT;
         ST_INIT:  state_d = init ? ST_INIT : ST_IDLE;
         ST_IDLE: begin
            if (any_err)                     state_d = ST_ERROR;
            else if (init)                   state_d = ST_INIT;
            else if (!vc0_empty || !vc1_empty) state_d = ST_ACTIVE;
         end
         ST_ACTIVE: begin
            if (any_err)                     state_d = ST_ERROR;
            else if (init)                   state_d = ST_INIT;
            else if (vc0_empty && vc1_empty && !in_flight) state_d = ST_IDLE;
         end
         ST_ERROR: if (init) state_d = ST_INIT;
         default:  state_d = ST_RESET;
      endcase
      // Reads only while staying in ACTIVE and neither destination is near full
      rd_ok = (state_q == ST_ACTIVE) && (state_d == ST_ACTIVE) &&
              !d0_almost_full && !d1_almost_full;
      rd0_d = rd_ok && !vc0_empty;
      rd1_d = rd_ok && vc0_empty && !vc1_empty;
   end

   // State, thresholds, read strobes and the write stage that trails each read
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_RESET;
         fifo_init <= 1'b0;
         idle_out  <= 1'b0;
         umbral_D0 <= 4'd0;
         umbral_D1 <= 4'd0;
         vc0_rd    <= 1'b0;
         vc1_rd    <= 1'b0;
         d0_wr     <= 1'b0;
         d1_wr     <= 1'b0;
         data_out  <= '0;
      end else begin
         state_q   <= state_d;
         fifo_init <= (state_d == ST_IDLE) || (state_d == ST_ACTIVE) || (state_d == ST_ERROR);
         idle_out  <= (state_d == ST_IDLE);
         vc0_rd    <= rd0_d;
         vc1_rd    <= rd1_d;
         if (state_q == ST_INIT) begin
            umbral_D0 <= umbral_D0_in;
            umbral_D1 <= umbral_D1_in;
         end
         if (vc0_rd) begin
            data_out <= vc0_data;
            d1_wr    <= vc0_data[data_width-1];
            d0_wr    <= ~vc0_data[data_width-1];
         end else if (vc1_rd) begin
            data_out <= vc1_data;
            d1_wr    <= vc1_data[data_width-1];
            d0_wr    <= ~vc1_data[data_width-1];
         end else begin
            data_out <= '0;
            d1_wr    <= 1'b0;
            d0_wr    <= 1'b0;
         end
      end
   end

   assign state = state_q;

endmodule

// File: tb/tb_fifo_arb_ctrl.sv
// Scoreboard bench for fifo_arb_ctrl: upstream FIFOs modelled as queues, a behavioural
// reference predicts every cycle's outputs and the ordered stream of written words.
module tb_fifo_arb_ctrl;
   localparam int unsigned W = 6;

   logic         clk = 1'b0;
   logic         reset, init;
   logic [3:0]   umbral_D0_in, umbral_D1_in;
   logic         vc0_empty, vc1_empty;
   logic [W-1:0] vc0_data, vc1_data;
   logic         d0_almost_full, d1_almost_full;
   logic [3:0]   error_in;
   logic [4:0]   state;
   logic         fifo_init;
   logic [3:0]   umbral_D0, umbral_D1;
   logic         vc0_rd, vc1_rd, d0_wr, d1_wr;
   logic [W-1:0] data_out;
   logic         idle_out;

   always #5 clk = ~clk;

   fifo_arb_ctrl #(.data_width(W)) dut (
      .clk(clk), .reset(reset), .init(init),
      .umbral_D0_in(umbral_D0_in), .umbral_D1_in(umbral_D1_in),
      .vc0_empty(vc0_empty), .vc1_empty(vc1_empty),
      .vc0_data(vc0_data), .vc1_data(vc1_data),
      .d0_almost_full(d0_almost_full), .d1_almost_full(d1_almost_full),
      .error_in(error_in), .state(state), .fifo_init(fifo_init),
      .umbral_D0(umbral_D0), .umbral_D1(umbral_D1),
      .vc0_rd(vc0_rd), .vc1_rd(vc1_rd), .d0_wr(d0_wr), .d1_wr(d1_wr),
      .data_out(data_out), .idle_out(idle_out)
   );

   typedef enum int {M_RESET, M_INIT, M_IDLE, M_ACTIVE, M_ERROR} mstate_e;
   typedef struct packed {
      logic [4:0]   st;
      logic         fi, idle, rd0, rd1, w0, w1;
      logic [W-1:0] dout;
      logic [3:0]   u0, u1;
   } exp_t;

   exp_t         exp_q[$];
   logic [W-1:0] wr_q[$];
   logic [W-1:0] vc0_q[$], vc1_q[$];

   mstate_e    ms = M_RESET;
   bit         m_rd0 = 0, m_rd1 = 0;
   logic [3:0] mu0 = 4'd0, mu1 = 4'd0;
   int         checks = 0, errors = 0, cyc = 0;

   function automatic logic [4:0] onehot(mstate_e s);
      return 5'(1 << int'(s));
   endfunction

   // One clock of stimulus; the reference model predicts the state after the coming edge
   task automatic cycle(input bit rst, input bit ini, input logic [3:0] err,
                        input bit a0, input bit a1, input bit p0, input bit p1,
                        input logic [W-1:0] w0, input logic [W-1:0] w1,
                        input logic [3:0] u0, input logic [3:0] u1);
      exp_t         e;
      mstate_e      nx;
      bit           pop0, pop1, wr, can_rd, inflight;
      logic [W-1:0] word;
      @(negedge clk);
      if (p0) vc0_q.push_back(w0);
      if (p1) vc1_q.push_back(w1);
      reset = rst; init = ini; error_in = err;
      d0_almost_full = a0; d1_almost_full = a1;
      umbral_D0_in = u0; umbral_D1_in = u1;
      // Upstream FIFO: head word on the bus, empty once the word under read is the last one
      vc0_empty = (int'(vc0_q.size()) - int'(m_rd0)) <= 0;
      vc1_empty = (int'(vc1_q.size()) - int'(m_rd1)) <= 0;
      vc0_data  = (vc0_q.size() > 0) ? vc0_q[0] : '0;
      vc1_data  = (vc1_q.size() > 0) ? vc1_q[0] : '0;
      pop0 = m_rd0; pop1 = m_rd1;
      inflight = m_rd0 | m_rd1;
      wr = 1'b0; word = '0;
      if (m_rd0)      begin wr = 1'b1; word = vc0_data; end
      else if (m_rd1) begin wr = 1'b1; word = vc1_data; end
      if (rst) begin
         ms = M_RESET; m_rd0 = 0; m_rd1 = 0; mu0 = 4'd0; mu1 = 4'd0; wr = 1'b0; word = '0;
      end else begin
         nx = ms;
         case (ms)
            M_RESET: nx = M_INIT;
            M_INIT:  begin mu0 = u0; mu1 = u1; nx = ini ? M_INIT : M_IDLE; end
            M_IDLE, M_ACTIVE: begin
               if (err != 4'd0) nx = M_ERROR;
               else if (ini)    nx = M_INIT;
               else if (ms == M_IDLE) nx = (!vc0_empty || !vc1_empty) ? M_ACTIVE : M_IDLE;
               else nx = (vc0_empty && vc1_empty && !inflight) ? M_IDLE : M_ACTIVE;
            end
            M_ERROR: if (ini) nx = M_INIT;
            default: nx = M_RESET;
         endcase
         can_rd = (ms == M_ACTIVE) && (nx == M_ACTIVE) && !a0 && !a1;
         m_rd0 = can_rd && !vc0_empty;
         m_rd1 = can_rd && vc0_empty && !vc1_empty;
         ms = nx;
      end
      if (pop0 && vc0_q.size() > 0) void'(vc0_q.pop_front());
      if (pop1 && vc1_q.size() > 0) void'(vc1_q.pop_front());
      if (wr) wr_q.push_back(word);
      e.st   = onehot(ms);
      e.fi   = (ms == M_IDLE) || (ms == M_ACTIVE) || (ms == M_ERROR);
      e.idle = (ms == M_IDLE);
      e.rd0  = m_rd0; e.rd1 = m_rd1;
      e.w1   = wr && word[W-1];
      e.w0   = wr && !word[W-1];
      e.dout = wr ? word : '0;
      e.u0   = mu0; e.u1 = mu1;
      exp_q.push_back(e);
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) cycle(0, 0, 4'd0, 0, 0, 0, 0, '0, '0, 4'd0, 4'd0);
   endtask

   // Monitor: per-cycle output compare plus in-order check of every downstream write
   initial begin
      exp_t e, got;
      logic [W-1:0] w;
      forever begin
         @(posedge clk); #1;
         cyc++;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            got = {state, fifo_init, idle_out, vc0_rd, vc1_rd, d0_wr, d1_wr,
                   data_out, umbral_D0, umbral_D1};
            checks++;
            if (got !== e) begin
               errors++;
               $display("FAIL outputs cyc=%0d got st=%b fi=%b idle=%b rd=%b%b wr=%b%b dout=%h u=%h/%h exp st=%b fi=%b idle=%b rd=%b%b wr=%b%b dout=%h u=%h/%h",
                        cyc, got.st, got.fi, got.idle, got.rd0, got.rd1, got.w1, got.w0, got.dout, got.u0, got.u1,
                        e.st, e.fi, e.idle, e.rd0, e.rd1, e.w1, e.w0, e.dout, e.u0, e.u1);
            end
         end
         if (d0_wr === 1'b1 || d1_wr === 1'b1) begin
            checks++;
            if (wr_q.size() == 0) begin
               errors++;
               $display("FAIL write_order cyc=%0d got unexpected write dout=%h exp no write", cyc, data_out);
            end else begin
               w = wr_q.pop_front();
               if (data_out !== w || d1_wr !== w[W-1] || d0_wr !== ~w[W-1]) begin
                  errors++;
                  $display("FAIL write_order cyc=%0d got dout=%h d1=%b d0=%b exp dout=%h d1=%b d0=%b",
                           cyc, data_out, d1_wr, d0_wr, w, w[W-1], ~w[W-1]);
               end
            end
         end
      end
   end

   initial begin
      reset = 1'b1; init = 1'b1; error_in = 4'd0;
      umbral_D0_in = 4'd0; umbral_D1_in = 4'd0;
      vc0_empty = 1'b1; vc1_empty = 1'b1; vc0_data = '0; vc1_data = '0;
      d0_almost_full = 1'b0; d1_almost_full = 1'b0;

      // Power-up: two reset cycles, INIT with thresholds 3/5, then IDLE
      repeat (2) cycle(1, 1, 4'd0, 0, 0, 0, 0, '0, '0, 4'd3, 4'd5);
      cycle(0, 1, 4'd0, 0, 0, 0, 0, '0, '0, 4'd3, 4'd5);
      cycle(0, 0, 4'd0, 0, 0, 0, 0, '0, '0, 4'd3, 4'd5);
      idle_cycles(2);

      // Priority: both VCs loaded, VC0 served first
      cycle(0, 0, 4'd0, 0, 0, 1, 1, 6'h25, 6'h05, 4'd0, 4'd0);
      idle_cycles(6);

      // Back-pressure on D0 while words wait, then release
      cycle(0, 0, 4'd0, 1, 0, 1, 1, 6'h11, 6'h32, 4'd0, 4'd0);
      repeat (3) cycle(0, 0, 4'd0, 1, 0, 0, 0, '0, '0, 4'd0, 4'd0);
      idle_cycles(6);

      // Error during transfer, sticky, left via init
      cycle(0, 0, 4'd0, 0, 0, 1, 0, 6'h21, '0, 4'd0, 4'd0);
      cycle(0, 0, 4'd0, 0, 0, 1, 0, 6'h02, '0, 4'd0, 4'd0);
      cycle(0, 0, 4'd0, 0, 0, 1, 0, 6'h23, '0, 4'd0, 4'd0);
      cycle(0, 0, 4'b0100, 0, 0, 0, 0, '0, '0, 4'd0, 4'd0);
      idle_cycles(3);
      cycle(0, 1, 4'd0, 0, 0, 0, 0, '0, '0, 4'd7, 4'd9);
      cycle(0, 0, 4'd0, 0, 0, 0, 0, '0, '0, 4'd7, 4'd9);
      idle_cycles(6);

      // Reset right after a VC1 read is issued
      cycle(0, 0, 4'd0, 0, 0, 0, 1, '0, 6'h3c, 4'd0, 4'd0);
      cycle(0, 0, 4'd0, 0, 0, 0, 0, '0, '0, 4'd0, 4'd0);
      cycle(1, 0, 4'd0, 0, 0, 0, 0, '0, '0, 4'd0, 4'd0);
      cycle(0, 0, 4'd0, 0, 0, 0, 0, '0, '0, 4'd4, 4'd6);
      cycle(0, 0, 4'd0, 0, 0, 0, 0, '0, '0, 4'd4, 4'd6);
      idle_cycles(4);

      // Drain: three words with alternating destination queued behind back-pressure
      cycle(0, 0, 4'd0, 0, 1, 1, 0, 6'h01, '0, 4'd0, 4'd0);
      cycle(0, 0, 4'd0, 0, 1, 1, 0, 6'h22, '0, 4'd0, 4'd0);
      cycle(0, 0, 4'd0, 0, 1, 1, 0, 6'h03, '0, 4'd0, 4'd0);
      idle_cycles(8);

      // Randomised traffic with occasional reset, init and error events
      for (int i = 0; i < 3000; i++) begin
         cycle(($urandom % 100) < 2, ($urandom % 100) < 4,
               (($urandom % 100) < 3) ? 4'(($urandom % 15) + 1) : 4'd0,
               ($urandom % 100) < 15, ($urandom % 100) < 15,
               ($urandom % 100) < 45, ($urandom % 100) < 45,
               W'($urandom), W'($urandom), 4'($urandom), 4'($urandom));
      end
      idle_cycles(4);
      @(posedge clk); #2;

      checks++;
      if (wr_q.size() != 0) begin
         errors++;
         $display("FAIL missing_writes got %0d outstanding exp 0", wr_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fifo_arb_ctrl.md
FIFO_ARB_CTRL -- requirements
Module: fifo_arb_ctrl

Interface
REQ-001 Parameter data_width, default 6, width of every data word; bit data_width-1 is the destination bit (0 = D0, 1 = D1).
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 init  input  1  request to (re)enter INIT and reload thresholds.
REQ-005 umbral_D0_in, umbral_D1_in  input  4 each  threshold values, sampled only in INIT.
REQ-006 vc0_empty, vc1_empty  input  1 each  upstream FIFO empty flags.
REQ-007 vc0_data, vc1_data  input  data_width each  upstream FIFO registered read data.
REQ-008 d0_almost_full, d1_almost_full  input  1 each  downstream almost-full flags.
REQ-009 error_in  input  4  error flags {d1, d0, vc1, vc0}.
REQ-010 state  output  5  one-hot state: RESET=00001, INIT=00010, IDLE=00100, ACTIVE=01000, ERROR=10000.
REQ-011 fifo_init  output  1  drives the init port of all four FIFOs.
REQ-012 umbral_D0, umbral_D1  output  4 each  registered thresholds to the downstream FIFOs.
REQ-013 vc0_rd, vc1_rd  output  1 each  upstream read enables.
REQ-014 d0_wr, d1_wr  output  1 each  downstream write enables.
REQ-015 data_out  output  data_width  word written downstream.
REQ-016 idle_out  output  1  high only in IDLE.

Function
REQ-017 All outputs are registered; no output depends combinationally on an input.
REQ-018 RESET goes to INIT on the first clk edge with reset low.
REQ-019 INIT loads umbral_D0/D1 from their inputs every cycle; it stays in INIT while init=1 and goes to IDLE on the first edge with init=0.
REQ-020 IDLE goes to ACTIVE when vc0_empty=0 or vc1_empty=0; otherwise it stays in IDLE.
REQ-021 ACTIVE goes to IDLE when both VCs are empty and no read is in flight.
REQ-022 From IDLE or ACTIVE, any error_in bit = 1 goes to ERROR; otherwise init=1 goes to INIT. Error has priority over init.
REQ-023 ERROR is sticky; it leaves only via reset (to RESET) or init=1 (to INIT).
REQ-024 fifo_init = 1 only in IDLE, ACTIVE and ERROR; it is 0 in RESET and INIT.
REQ-025 Reads are issued only in ACTIVE, only when d0_almost_full = 0 and d1_almost_full = 0, and at most one read per cycle.
REQ-026 Arbitration is strict priority: vc0_rd when vc0_empty=0; else vc1_rd when vc1_empty=0.
REQ-027 A read issued at edge N causes a write at edge N+1:
- data_out = data of the granted VC;
- d1_wr = data_out[data_width-1];
- d0_wr = its complement.
REQ-028 A write follows its read even if the state leaves ACTIVE in between.
REQ-029 When no write occurs: d0_wr = 0, d1_wr = 0, data_out = 0.
REQ-030 Back-to-back reads are permitted; sustained throughput is one word per cycle.

Reset
REQ-031 While reset = 1 at an edge:
- state = RESET;
- fifo_init, vc0_rd, vc1_rd, d0_wr, d1_wr, idle_out = 0;
- data_out = 0; umbral_D0 = 0; umbral_D1 = 0;
- the in-flight read flag is cleared.
REQ-032 Reset asserted mid-transfer cancels the pending write: the next-cycle d0_wr and d1_wr are 0.

Verification
REQ-033 Power-up: reset=1 for 2 cycles, init=1, umbral_D0_in=3, umbral_D1_in=5, then init=0 -> RESET, INIT, IDLE; umbral_D0=3, umbral_D1=5; fifo_init rises on entry to IDLE; idle_out=1.
REQ-034 Priority: both VCs non-empty, vc0_data=6'h25, vc1_data=6'h05 -> ACTIVE; vc0_rd=1, vc1_rd=0; next cycle d1_wr=1, data_out=6'h25.
REQ-035 Back-pressure: d0_almost_full=1 while VCs are non-empty -> no rd asserted; reads resume the cycle after it drops.
REQ-036 Error: error_in=4'b0100 during ACTIVE -> ERROR next cycle; the pending write still completes; state stays ERROR until init=1, then goes to INIT.
REQ-037 Reset mid-transfer: reset=1 the cycle after vc1_rd=1 -> d0_wr=0, d1_wr=0, state=RESET.
REQ-038 Drain: VC0 holds 3 words with alternating destination bit -> three consecutive writes alternating d0_wr and d1_wr, then IDLE.
